// File: rtl/arm_pipe_pkg.sv
// Shared pipeline definitions: the never-executed filler instruction, fetch FSM encoding
// and the IF/ID payload type.
package arm_pipe_pkg;

    localparam logic [31:0] NOP_INSTR       = 32'hF000_0000;
    localparam logic [31:0] PC_STEP_DEFAULT = 32'd4;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_word_t;

    // Sequential PC advance; plain modulo-2^32 wrap.
    function automatic logic [31:0] pc_advance(input logic [31:0] pc, input logic [31:0] step);
        return pc + step;
    endfunction

endpackage

// File: rtl/if_stage_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and memory (slave).
interface if_stage_fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_stage_fetch_if_id_reg.sv
// Pipeline register between two stages: load takes a real word or a bubble, flush forces a
// bubble; a bubble keeps the old pc so downstream sees a stable address.
module if_id_reg
    import arm_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    logic        valid_r;
    logic [31:0] pc_r;
    logic [31:0] instr_r;

    // Register update: reset, flush to bubble, load word/bubble, or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            pc_r    <= 32'h0000_0000;
            instr_r <= NOP_INSTR;
        end else if (flush) begin
            valid_r <= 1'b0;
            instr_r <= NOP_INSTR;
        end else if (load) begin
            if (in_valid) begin
                valid_r <= 1'b1;
                pc_r    <= in_pc;
                instr_r <= in_instr;
            end else begin
                valid_r <= 1'b0;
                instr_r <= NOP_INSTR;
            end
        end
    end

    assign out_valid = valid_r;
    assign out_pc    = pc_r;
    assign out_instr = instr_r;

endmodule

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: owns the PC, keeps one memory request in flight, buffers a response
// that arrives during a freeze, and redirects on a taken branch while discarding wrong-path data.
module if_stage_fetch
    import arm_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [31:0]        branch_addr,
    if_stage_fetch_if.master   imem,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_instruction,
    output logic               if_valid
);

    localparam logic [1:0] ST_REQ  = FETCH_REQ;
    localparam logic [1:0] ST_WAIT = FETCH_WAIT;
    localparam logic [1:0] ST_DROP = FETCH_DROP;

    logic [1:0]  state_r;
    logic [1:0]  state_next_s;
    logic [31:0] pc_r;
    logic [31:0] tag_r;
    logic        skid_valid_r;
    fetch_word_t skid_r;

    logic        req_s;
    logic        accept_s;
    logic        resp_s;
    logic        load_s;
    logic        src_valid_s;
    fetch_word_t src_s;
    fetch_word_t resp_word_s;

    // A full skid means the next word is already buffered, so no new request is issued.
    assign req_s       = (state_r == ST_REQ) && !skid_valid_r && !rst;
    assign accept_s    = req_s && imem.imem_ready;
    assign resp_s      = (state_r == ST_WAIT) && imem.imem_rvalid;
    assign load_s      = !freeze && !branch_taken;
    assign resp_word_s = '{pc: pc_advance(tag_r, PC_STEP), instr: imem.imem_rdata};

    assign imem.imem_req  = req_s;
    assign imem.imem_addr = pc_r;

    // IF/ID source select: buffered word first, then the live response, else a bubble.
    always_comb begin
        src_valid_s = 1'b0;
        src_s       = resp_word_s;
        if (skid_valid_r) begin
            src_valid_s = 1'b1;
            src_s       = skid_r;
        end else if (resp_s) begin
            src_valid_s = 1'b1;
            src_s       = resp_word_s;
        end else begin
            src_valid_s = 1'b0;
            src_s       = resp_word_s;
        end
    end

    // Fetch FSM next state; a redirect while a request is in flight must swallow its response.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_REQ: begin
                if (accept_s) begin
                    state_next_s = branch_taken ? ST_DROP : ST_WAIT;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem.imem_rvalid) begin
                    state_next_s = ST_REQ;
                end else if (branch_taken) begin
                    state_next_s = ST_DROP;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (imem.imem_rvalid) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_DROP;
                end
            end
            default: state_next_s = ST_REQ;
        endcase
    end

    // FSM, PC, response tag and skid state; reset still drains a pre-reset outstanding response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= (((state_r == ST_WAIT) || (state_r == ST_DROP)) && !imem.imem_rvalid)
                            ? ST_DROP : ST_REQ;
            pc_r         <= RESET_PC;
            tag_r        <= RESET_PC;
            skid_valid_r <= 1'b0;
            skid_r       <= '{pc: 32'h0000_0000, instr: NOP_INSTR};
        end else begin
            state_r <= state_next_s;
            if (branch_taken) begin
                pc_r <= branch_addr;
            end else if (accept_s) begin
                pc_r <= pc_advance(pc_r, PC_STEP);
            end
            if (accept_s) begin
                tag_r <= pc_r;
            end
            if (branch_taken) begin
                skid_valid_r <= 1'b0;
            end else if (load_s) begin
                skid_valid_r <= skid_valid_r && resp_s;
                skid_r       <= resp_word_s;
            end else if (resp_s) begin
                skid_valid_r <= 1'b1;
                skid_r       <= resp_word_s;
            end
        end
    end

    if_id_reg u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .flush     (branch_taken),
        .in_valid  (src_valid_s),
        .in_pc     (src_s.pc),
        .in_instr  (src_s.instr),
        .out_valid (if_valid),
        .out_pc    (if_pc),
        .out_instr (if_instruction)
    );

endmodule

// File: tb/tb_if_stage_fetch.sv
// Directed bench for if_stage_fetch with a latency-programmable instruction memory model.
module tb_if_stage_fetch;
    import arm_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        if_valid;

    int checks = 0;
    int errors = 0;

    logic        ready_en = 1'b1;
    int          lat = 1;
    logic        acc_q = 1'b0;
    logic [31:0] acc_addr = 32'h0;
    logic [31:0] addr_q = 32'h0;
    int          cnt = 0;

    if_stage_fetch_if mif ();

    if_stage_fetch #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_addr    (branch_addr),
        .imem           (mif),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .if_valid       (if_valid)
    );

    always #5 clk = ~clk;

    assign mif.imem_ready = ready_en;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hE1A0_0000;
    endfunction

    // Sample acceptance mid-cycle.
    always @(negedge clk) begin
        acc_q    = mif.imem_req && mif.imem_ready;
        acc_addr = mif.imem_addr;
    end

    // Memory responder: one response, lat cycles after acceptance.
    initial begin
        mif.imem_rvalid = 1'b0;
        mif.imem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (acc_q) begin
                addr_q = acc_addr;
                cnt    = lat;
            end
            mif.imem_rvalid = 1'b0;
            if (cnt > 0) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    mif.imem_rvalid = 1'b1;
                    mif.imem_rdata  = mem_word(addr_q);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
        nxt(); nxt();
        mid();
        chk("rst_req",   {31'h0, mif.imem_req}, 32'd0);
        chk("rst_valid", {31'h0, if_valid}, 32'd0);
        chk("rst_instr", if_instruction, NOP_INSTR);
        chk("rst_pc",    if_pc, 32'h0);
        chk("rst_addr",  mif.imem_addr, 32'h0);

        // Sequential fetch, 1-cycle memory.
        nxt(); rst = 1'b0;
        mid(); chk("c0_req", {31'h0, mif.imem_req}, 32'd1); chk("c0_addr", mif.imem_addr, 32'h0);
        nxt(); mid(); chk("c1_req", {31'h0, mif.imem_req}, 32'd0);
        nxt(); mid();
        chk("seq0_valid", {31'h0, if_valid}, 32'd1);
        chk("seq0_pc", if_pc, 32'h4);
        chk("seq0_instr", if_instruction, mem_word(32'h0));
        chk("seq0_addr", mif.imem_addr, 32'h4);
        nxt(); mid();
        chk("seq_bubble_valid", {31'h0, if_valid}, 32'd0);
        chk("seq_bubble_pc", if_pc, 32'h4);
        nxt(); mid();
        chk("seq1_pc", if_pc, 32'h8);
        chk("seq1_instr", if_instruction, mem_word(32'h4));
        nxt();

        // Freeze for 3 cycles while a response lands in the skid.
        nxt(); freeze = 1'b1;
        mid();
        chk("seq2_pc", if_pc, 32'hC);
        chk("seq2_instr", if_instruction, mem_word(32'h8));
        chk("frz_addr", mif.imem_addr, 32'hC);
        nxt(); mid(); chk("frz_hold_pc", if_pc, 32'hC);
        nxt(); mid();
        chk("frz_hold_pc2", if_pc, 32'hC);
        chk("frz_hold_instr", if_instruction, mem_word(32'h8));
        chk("frz_hold_valid", {31'h0, if_valid}, 32'd1);
        chk("frz_skid_noreq", {31'h0, mif.imem_req}, 32'd0);
        nxt(); freeze = 1'b0;
        mid(); chk("rel_noreq", {31'h0, mif.imem_req}, 32'd0);
        nxt(); lat = 3;
        mid();
        chk("rel_pc", if_pc, 32'h10);
        chk("rel_instr", if_instruction, mem_word(32'hC));
        chk("rel_valid", {31'h0, if_valid}, 32'd1);
        chk("rel_addr", mif.imem_addr, 32'h10);

        // Redirect while waiting on a 3-cycle memory.
        nxt(); branch_taken = 1'b1; branch_addr = 32'h100;
        mid(); chk("br_pre_valid", {31'h0, if_valid}, 32'd0);
        nxt(); branch_taken = 1'b0;
        mid(); chk("drop_noreq", {31'h0, mif.imem_req}, 32'd0);
        nxt(); mid(); chk("drop_noreq2", {31'h0, mif.imem_req}, 32'd0);
        nxt(); mid();
        chk("br_req", {31'h0, mif.imem_req}, 32'd1);
        chk("br_addr", mif.imem_addr, 32'h100);
        chk("br_stale_valid", {31'h0, if_valid}, 32'd0);
        nxt(); nxt(); nxt(); mid();
        chk("br_wait_valid", {31'h0, if_valid}, 32'd0);

        // Branch together with freeze, request held off by imem_ready.
        nxt(); ready_en = 1'b0; freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h200; lat = 1;
        mid();
        chk("br_tgt_pc", if_pc, 32'h104);
        chk("br_tgt_instr", if_instruction, mem_word(32'h100));
        chk("br_tgt_valid", {31'h0, if_valid}, 32'd1);
        nxt(); freeze = 1'b0; branch_taken = 1'b0;
        mid();
        chk("bf_valid", {31'h0, if_valid}, 32'd0);
        chk("bf_instr", if_instruction, NOP_INSTR);
        chk("bf_pc", if_pc, 32'h104);
        chk("bf_req", {31'h0, mif.imem_req}, 32'd1);
        chk("bf_addr", mif.imem_addr, 32'h200);
        for (int i = 0; i < 3; i++) begin
            nxt(); mid();
            chk("rdy_low_req", {31'h0, mif.imem_req}, 32'd1);
            chk("rdy_low_addr", mif.imem_addr, 32'h200);
        end
        nxt(); ready_en = 1'b1;
        mid(); chk("rdy_acc_addr", mif.imem_addr, 32'h200);
        nxt(); mid();
        chk("rdy_pc_step", mif.imem_addr, 32'h204);
        chk("rdy_wait_noreq", {31'h0, mif.imem_req}, 32'd0);

        // PC wrap at the top of the address space.
        nxt(); ready_en = 1'b0; branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
        mid();
        chk("rdy_if_pc", if_pc, 32'h204);
        chk("rdy_if_instr", if_instruction, mem_word(32'h200));
        nxt(); branch_taken = 1'b0; ready_en = 1'b1;
        mid();
        chk("wrap_req", {31'h0, mif.imem_req}, 32'd1);
        chk("wrap_addr", mif.imem_addr, 32'hFFFF_FFFC);
        nxt(); mid(); chk("wrap_pc", mif.imem_addr, 32'h0);
        nxt(); lat = 3;
        mid();
        chk("wrap_if_pc", if_pc, 32'h0);
        chk("wrap_if_instr", if_instruction, mem_word(32'hFFFF_FFFC));
        chk("wrap_if_valid", {31'h0, if_valid}, 32'd1);

        // Reset while a 3-cycle request is outstanding.
        nxt(); rst = 1'b1;
        nxt(); rst = 1'b0;
        mid();
        chk("prst_req", {31'h0, mif.imem_req}, 32'd0);
        chk("prst_valid", {31'h0, if_valid}, 32'd0);
        chk("prst_instr", if_instruction, NOP_INSTR);
        chk("prst_pc", if_pc, 32'h0);
        nxt(); mid(); chk("prst_drop_req", {31'h0, mif.imem_req}, 32'd0);
        nxt(); lat = 1;
        mid();
        chk("prst_req2", {31'h0, mif.imem_req}, 32'd1);
        chk("prst_addr", mif.imem_addr, 32'h0);
        chk("prst_stale_valid", {31'h0, if_valid}, 32'd0);
        nxt(); mid(); chk("prst_wait_valid", {31'h0, if_valid}, 32'd0);

        // Redirect in the same cycle the request is accepted.
        nxt(); branch_taken = 1'b1; branch_addr = 32'h300;
        mid();
        chk("prst_if_pc", if_pc, 32'h4);
        chk("prst_if_instr", if_instruction, mem_word(32'h0));
        chk("prst_if_valid", {31'h0, if_valid}, 32'd1);
        chk("acbr_addr_old", mif.imem_addr, 32'h4);
        nxt(); branch_taken = 1'b0;
        mid();
        chk("acbr_drop_req", {31'h0, mif.imem_req}, 32'd0);
        chk("acbr_valid", {31'h0, if_valid}, 32'd0);
        nxt(); mid();
        chk("acbr_req", {31'h0, mif.imem_req}, 32'd1);
        chk("acbr_addr", mif.imem_addr, 32'h300);
        chk("acbr_stale_valid", {31'h0, if_valid}, 32'd0);

        nxt(); nxt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
